// File: rtl/flip_engine.sv
// Reversi capture/flip stage: walks 8 directions from the placed cell and flips bracketed discs.
// Latency: 1 + W + F clock edges from start acceptance to done (W = cells examined, F = discs flipped).
// Backpressure: none; start is only sampled in IDLE, and busy is high while a move is in progress.
module flip_engine #(
  parameter int SIDE    = 8,
  parameter int CELL_W  = 3,
  parameter int BOARD_W = SIDE * SIDE * CELL_W
) (
  input  logic               clk,
  input  logic               resetn,        // active-high synchronous reset
  input  logic               start,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [6:0]         index,
  input  logic               player_black,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [4:0]         flip_count,
  output logic [BOARD_W-1:0] board_out
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_FLIP, S_DONE} state_t;

  state_t state_q, state_d;

  logic [BOARD_W-1:0] board_q, board_d;
  logic [BOARD_W-1:0] board_out_q, board_out_d;
  logic               player_q, player_d;
  logic [2:0]         dir_q, dir_d;
  logic [2:0]         run_q, run_d;
  logic [4:0]         count_q, count_d;
  logic [4:0]         flip_count_q, flip_count_d;
  logic               err_q, err_d;
  logic [2:0]         org_r_q, org_r_d, org_c_q, org_c_d;
  logic [2:0]         cur_r_q, cur_r_d, cur_c_q, cur_c_d;

  // Placed-cell decode. A 7-bit index can never exceed 189, so only the
  // multiple-of-3 test can reject it.
  logic       idx_ok;
  logic [5:0] k_in;
  logic [2:0] own_cell;

  // Direction vector and neighbour lookup for the walk / flip cursors.
  logic signed [4:0] dr, dc, nr, nc;
  logic [2:0]        fr, fc;
  logic [7:0]        n_bit, f_bit;
  logic [2:0]        n_cell;
  logic              off_board, is_opp, is_own;
  logic              walk_flip, walk_adv, flip_last, adv, last_dir;

  // Decode the step delta for the current direction (N, NE, E, SE, S, SW, W, NW).
  always_comb begin
    dr = 5'sd0;
    dc = 5'sd0;
    case (dir_q)
      3'd0: begin dr = -5'sd1; dc =  5'sd0; end
      3'd1: begin dr = -5'sd1; dc =  5'sd1; end
      3'd2: begin dr =  5'sd0; dc =  5'sd1; end
      3'd3: begin dr =  5'sd1; dc =  5'sd1; end
      3'd4: begin dr =  5'sd1; dc =  5'sd0; end
      3'd5: begin dr =  5'sd1; dc = -5'sd1; end
      3'd6: begin dr =  5'sd0; dc = -5'sd1; end
      default: begin dr = -5'sd1; dc = -5'sd1; end
    endcase
  end

  // Classify the next cell along the walk and the cell being rewritten in FLIP.
  always_comb begin
    idx_ok    = (index % 7'd3) == 7'd0;
    k_in      = 6'(index / 7'd3);
    own_cell  = {2'b11, player_q};
    nr        = $signed({2'b00, cur_r_q}) + dr;
    nc        = $signed({2'b00, cur_c_q}) + dc;
    // Rows/cols outside 0..7 show up as bit 4 (negative) or bit 3 (== 8);
    // this is what stops an E step from column 7 wrapping to the next row.
    off_board = nr[4] | nr[3] | nc[4] | nc[3];
    n_bit     = {2'b00, nr[2:0], nc[2:0]} * 8'd3;
    n_cell    = board_q[n_bit +: CELL_W];
    is_opp    = !off_board && n_cell[2] && (n_cell[0] != player_q);
    is_own    = !off_board && n_cell[2] && (n_cell[0] == player_q);
    // Flip cursor steps back toward the origin; the result is always on-board,
    // so modulo-8 arithmetic on the low bits is exact.
    fr        = cur_r_q - dr[2:0];
    fc        = cur_c_q - dc[2:0];
    f_bit     = {2'b00, fr, fc} * 8'd3;
    last_dir  = dir_q == 3'd7;
    walk_flip = (state_q == S_WALK) && is_own && (run_q != 3'd0);
    walk_adv  = (state_q == S_WALK) && !is_opp && !walk_flip;
    flip_last = (state_q == S_FLIP) && (run_q == 3'd1);
    adv       = walk_adv || flip_last;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = idx_ok ? S_WALK : S_DONE;
      S_WALK: begin
        if (walk_flip)     state_d = S_FLIP;
        else if (adv)      state_d = last_dir ? S_DONE : S_WALK;
      end
      S_FLIP: if (adv)     state_d = last_dir ? S_DONE : S_WALK;
      default:             state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch request, step cursor, rewrite cells, publish on DONE entry.
  always_comb begin
    board_d      = board_q;
    board_out_d  = board_out_q;
    player_d     = player_q;
    dir_d        = dir_q;
    run_d        = run_q;
    count_d      = count_q;
    flip_count_d = flip_count_q;
    err_d        = err_q;
    org_r_d      = org_r_q;
    org_c_d      = org_c_q;
    cur_r_d      = cur_r_q;
    cur_c_d      = cur_c_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          board_d  = board_in;
          player_d = player_black;
          dir_d    = 3'd0;
          run_d    = 3'd0;
          count_d  = 5'd0;
          err_d    = !idx_ok;
          org_r_d  = k_in[5:3];
          org_c_d  = k_in[2:0];
          cur_r_d  = k_in[5:3];
          cur_c_d  = k_in[2:0];
        end
      end
      S_WALK: begin
        if (is_opp || walk_flip) begin
          cur_r_d = nr[2:0];
          cur_c_d = nc[2:0];
          if (is_opp) run_d = run_q + 3'd1;
        end
      end
      S_FLIP: begin
        board_d[f_bit +: CELL_W] = own_cell;
        cur_r_d = fr;
        cur_c_d = fc;
        run_d   = run_q - 3'd1;
        count_d = count_q + 5'd1;
      end
      default: ;
    endcase

    if (adv) begin
      dir_d   = dir_q + 3'd1;
      run_d   = 3'd0;
      cur_r_d = org_r_q;
      cur_c_d = org_c_q;
    end

    // Results become visible in the same cycle that done is high.
    if (state_d == S_DONE) begin
      board_out_d  = board_d;
      flip_count_d = count_d;
    end
  end

  // FSM outputs.
  always_comb begin
    busy = state_q != S_IDLE;
    done = state_q == S_DONE;
  end

  assign err        = err_q;
  assign flip_count = flip_count_q;
  assign board_out  = board_out_q;

  // State register; reset abandons any walk in progress.
  always_ff @(posedge clk) begin
    if (resetn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      board_q      <= '0;
      board_out_q  <= '0;
      player_q     <= 1'b0;
      dir_q        <= 3'd0;
      run_q        <= 3'd0;
      count_q      <= 5'd0;
      flip_count_q <= 5'd0;
      err_q        <= 1'b0;
      org_r_q      <= 3'd0;
      org_c_q      <= 3'd0;
      cur_r_q      <= 3'd0;
      cur_c_q      <= 3'd0;
    end else begin
      board_q      <= board_d;
      board_out_q  <= board_out_d;
      player_q     <= player_d;
      dir_q        <= dir_d;
      run_q        <= run_d;
      count_q      <= count_d;
      flip_count_q <= flip_count_d;
      err_q        <= err_d;
      org_r_q      <= org_r_d;
      org_c_q      <= org_c_d;
      cur_r_q      <= cur_r_d;
      cur_c_q      <= cur_c_d;
    end
  end

endmodule

// File: tb/tb_flip_engine.sv
// Directed bench for flip_engine: table of moves with hand-computed boards, counts and latencies.
// Latency is counted in clock edges, the start-sampling edge being edge 1.
// Hand sequences cover reset mid-walk, start pulses while busy, and err clearing.
module tb_flip_engine;

  localparam logic [2:0] BLK = 3'b111;
  localparam logic [2:0] WHT = 3'b110;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [191:0] board_in;
  logic [6:0]   index;
  logic         player_black;
  logic         busy, done, err;
  logic [4:0]   flip_count;
  logic [191:0] board_out;

  always #5 clk = ~clk;

  flip_engine dut (
    .clk(clk), .resetn(resetn), .start(start), .board_in(board_in),
    .index(index), .player_black(player_black), .busy(busy), .done(done),
    .err(err), .flip_count(flip_count), .board_out(board_out)
  );

  typedef struct {
    logic [191:0] bin;
    logic [6:0]   idx;
    logic         pb;
    logic [191:0] bexp;
    logic [4:0]   cnt;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vt[7];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [191:0] put(input logic [191:0] b, input int k, input logic [2:0] v);
    logic [191:0] r;
    r = b;
    r[3*k +: 3] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Waits for done after the accept edge; expects to be called at accept edge + #1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic launch(input logic [191:0] b, input logic [6:0] idx, input logic pb);
    @(negedge clk);
    board_in     = b;
    index        = idx;
    player_black = pb;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [191:0] b;
    int lat;
    bit seen_done;

    resetn = 1'b1; start = 1'b0; board_in = '0; index = '0; player_black = 1'b0;

    // T1 opening: black at 19, flips 27 going south.
    b = '0;
    b = put(b, 19, BLK); b = put(b, 27, WHT); b = put(b, 28, BLK);
    b = put(b, 35, BLK); b = put(b, 36, WHT);
    vt[0] = '{b, 7'd57, 1'b1, put(b, 27, BLK), 5'd1, 1'b0, 11};
    // T2 multi-direction: white at 0 flips E (1,2), SE (9), S (8,16).
    b = '0;
    b = put(b, 0, WHT);
    b = put(b, 1, BLK); b = put(b, 2, BLK); b = put(b, 8, BLK);
    b = put(b, 16, BLK); b = put(b, 9, BLK);
    b = put(b, 3, WHT); b = put(b, 24, WHT); b = put(b, 18, WHT);
    vt[1].bin = b; vt[1].idx = 7'd0; vt[1].pb = 1'b0;
    b = put(b, 1, WHT); b = put(b, 2, WHT); b = put(b, 8, WHT);
    b = put(b, 16, WHT); b = put(b, 9, WHT);
    vt[1].bexp = b; vt[1].cnt = 5'd5; vt[1].e = 1'b0; vt[1].lat = 19;
    // T3 wrap guard: black at 7 must not see 8/9 on the next row.
    b = '0;
    b = put(b, 7, BLK); b = put(b, 8, WHT); b = put(b, 9, BLK);
    vt[2] = '{b, 7'd21, 1'b1, b, 5'd0, 1'b0, 9};
    // T4 unbracketed run to the east edge.
    b = '0;
    b = put(b, 0, BLK);
    for (int k = 1; k < 8; k++) b = put(b, k, WHT);
    vt[3] = '{b, 7'd0, 1'b1, b, 5'd0, 1'b0, 16};
    // T5 invalid index 58 on the T1 board.
    vt[4] = '{vt[0].bin, 7'd58, 1'b1, vt[0].bin, 5'd0, 1'b1, 1};
    // Largest 7-bit index, 127, is not a multiple of 3.
    vt[5] = '{vt[2].bin, 7'd127, 1'b0, vt[2].bin, 5'd0, 1'b1, 1};
    // Highest reachable cell 42 (index 126): white flips 43 going east.
    b = '0;
    b = put(b, 42, WHT); b = put(b, 43, BLK); b = put(b, 44, WHT);
    vt[6] = '{b, 7'd126, 1'b0, put(b, 43, WHT), 5'd1, 1'b0, 11};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_busy", {191'd0, busy}, 192'd0);
    chk("rst_done", {191'd0, done}, 192'd0);
    chk("rst_err", {191'd0, err}, 192'd0);
    chk("rst_count", {187'd0, flip_count}, 192'd0);
    chk("rst_board", board_out, 192'd0);

    // Table-driven moves.
    for (int i = 0; i < 7; i++) begin
      launch(vt[i].bin, vt[i].idx, vt[i].pb);
      chk($sformatf("v%0d_busy_acc", i), {191'd0, busy}, 192'd1);
      chk($sformatf("v%0d_err_acc", i), {191'd0, err}, {191'd0, vt[i].e});
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 192'(lat), 192'(vt[i].lat));
      chk($sformatf("v%0d_board", i), board_out, vt[i].bexp);
      chk($sformatf("v%0d_count", i), {187'd0, flip_count}, {187'd0, vt[i].cnt});
      chk($sformatf("v%0d_err", i), {191'd0, err}, {191'd0, vt[i].e});
      chk($sformatf("v%0d_busy_done", i), {191'd0, busy}, 192'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy_after", i), {191'd0, busy}, 192'd0);
      chk($sformatf("v%0d_done_pulse", i), {191'd0, done}, 192'd0);
    end

    // Result holds while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_board", board_out, vt[6].bexp);
    chk("hold_count", {187'd0, flip_count}, 192'd1);

    // T6: reset in the middle of T2's walk.
    launch(vt[1].bin, vt[1].idx, vt[1].pb);
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("t6_busy", {191'd0, busy}, 192'd0);
    chk("t6_board", board_out, 192'd0);
    chk("t6_count", {187'd0, flip_count}, 192'd0);
    seen_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("t6_no_done", {191'd0, seen_done}, 192'd0);

    // Re-issue T2 with stray start pulses (carrying the T1 move) while busy.
    launch(vt[1].bin, vt[1].idx, vt[1].pb);
    lat = 1;
    while (!done && lat < 300) begin
      if (lat == 3 || lat == 7) begin
        start = 1'b1; board_in = vt[0].bin; index = 7'd57; player_black = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("t6_latency", 192'(lat), 192'd19);
    chk("t6_rerun_board", board_out, vt[1].bexp);
    chk("t6_rerun_count", {187'd0, flip_count}, 192'd5);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_busy", {191'd0, busy}, 192'd0);
    chk("t6_idle_board", board_out, vt[1].bexp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
